fsmotor_step_gen: RTL and testbench

- Per-channel stepper command sequencer that sits directly upstream of the motor routing stage.
- Drives one routing-stage slave slot (xen, xrst, ms, drive, dir) and consumes the slot's zero-position-detect (zpd) return.
- Converts software commands (step count, half-period, direction, homing) into timed step pulses; tracks remaining steps and the homing result.
- One instance per motor; four instances feed slots s0..s3.

---
 rtl/fsmotor_step_gen.sv | 177 +++++++++++++++++
 tb/tb_fsmotor_step_gen.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsmotor_step_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fsmotor_step_gen
//  Purpose  : Per-motor stepper command sequencer. Turns software commands
//             (step count, half-period, direction, homing) into timed step
//             pulses for one routing-stage slave slot, tracks the remaining
//             step count and reports whether homing ended on zero detect.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             cfg_xen/xrst/ms     - slot enable/reset/microstep requests
//             req_start/home/stop - one-cycle command strobes
//             req_dir/steps/speed - run parameters (speed = half-period)
//             busy, done          - sequencer active / return-to-idle pulse
//             zero_hit, remain    - homing result, steps still to issue
//             motor_zpd           - zero-position detect from slot (async)
//             motor_xen/xrst/ms/drive/dir - slot outputs
//  Options  : FSMOTOR_STEP_GEN_ZPD_LIMIT_EN - zero detect also acts as a hard
//             limit for runs heading toward zero (dir == 0).
//  Revision : 1.0 - initial release
// ============================================================================
module fsmotor_step_gen #(
    parameter int C_MICROSTEP_WIDTH   = 3,
    parameter int C_STEP_NUMBER_WIDTH = 16,
    parameter int C_SPEED_DATA_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_xen,
    input  logic                           cfg_xrst,
    input  logic [C_MICROSTEP_WIDTH-1:0]   cfg_ms,
    input  logic                           req_start,
    input  logic                           req_home,
    input  logic                           req_stop,
    input  logic                           req_dir,
    input  logic [C_STEP_NUMBER_WIDTH-1:0] req_steps,
    input  logic [C_SPEED_DATA_WIDTH-1:0]  req_speed,
    output logic                           busy,
    output logic                           done,
    output logic                           zero_hit,
    output logic [C_STEP_NUMBER_WIDTH-1:0] remain,
    input  logic                           motor_zpd,
    output logic                           motor_xen,
    output logic                           motor_xrst,
    output logic [C_MICROSTEP_WIDTH-1:0]   motor_ms,
    output logic                           motor_drive,
    output logic                           motor_dir
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SETUP = 2'd1;
    localparam logic [1:0] c_ST_HIGH  = 2'd2;
    localparam logic [1:0] c_ST_LOW   = 2'd3;

    localparam logic c_MODE_RUN  = 1'b0;
    localparam logic c_MODE_HOME = 1'b1;

    localparam logic [C_SPEED_DATA_WIDTH-1:0]  c_SPD_ONE  = {{(C_SPEED_DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_STEP_NUMBER_WIDTH-1:0] c_STEP_ONE = {{(C_STEP_NUMBER_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]                     r_state;
    logic                           r_mode;
    logic [C_SPEED_DATA_WIDTH-1:0]  r_half;
    logic [C_SPEED_DATA_WIDTH-1:0]  r_cnt;
    logic [C_STEP_NUMBER_WIDTH-1:0] r_remain;
    logic                           r_zs_meta;
    logic                           r_zs;
    logic                           r_done;
    logic                           r_zero_hit;
    logic                           r_drive;
    logic                           r_dir;
    logic                           r_xen;
    logic                           r_xrst;
    logic [C_MICROSTEP_WIDTH-1:0]   r_ms;

    logic [C_SPEED_DATA_WIDTH-1:0]  w_half;
    logic                           w_zpd_abort;

    // A zero half-period would stall the phase counter; clamp to one clock.
    assign w_half = (req_speed == '0) ? c_SPD_ONE : req_speed;

    // r_dir is the latched run direction (homing forces it to 0).
`ifdef FSMOTOR_STEP_GEN_ZPD_LIMIT_EN
    assign w_zpd_abort = r_zs && ((r_mode == c_MODE_HOME) || (r_dir == 1'b0));
`else
    assign w_zpd_abort = r_zs && (r_mode == c_MODE_HOME);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_mode     <= c_MODE_RUN;
            r_half     <= c_SPD_ONE;
            r_cnt      <= '0;
            r_remain   <= '0;
            r_zs_meta  <= 1'b0;
            r_zs       <= 1'b0;
            r_done     <= 1'b0;
            r_zero_hit <= 1'b0;
            r_drive    <= 1'b0;
            r_dir      <= 1'b0;
            r_xen      <= 1'b0;
            r_xrst     <= 1'b1;
            r_ms       <= '0;
        end else begin
            r_zs_meta <= motor_zpd;
            r_zs      <= r_zs_meta;
            r_xen     <= cfg_xen;
            r_xrst    <= cfg_xrst;
            r_done    <= 1'b0;

            if (r_state == c_ST_IDLE) begin
                r_ms <= cfg_ms;
                // Stop outranks home, home outranks start; losers are dropped.
                if (!req_stop && req_home) begin
                    r_mode     <= c_MODE_HOME;
                    r_dir      <= 1'b0;
                    r_zero_hit <= 1'b0;
                    r_remain   <= '0;
                    r_half     <= w_half;
                    r_cnt      <= w_half - c_SPD_ONE;
                    r_state    <= c_ST_SETUP;
                end else if (!req_stop && req_start) begin
                    r_mode     <= c_MODE_RUN;
                    r_dir      <= req_dir;
                    r_zero_hit <= 1'b0;
                    r_remain   <= req_steps;
                    r_half     <= w_half;
                    r_cnt      <= w_half - c_SPD_ONE;
                    if (req_steps == '0) begin
                        r_done <= 1'b1;
                    end else begin
                        r_state <= c_ST_SETUP;
                    end
                end
            end else if (req_stop) begin
                r_state <= c_ST_IDLE;
                r_drive <= 1'b0;
                r_done  <= 1'b1;
            end else if (w_zpd_abort) begin
                r_state    <= c_ST_IDLE;
                r_drive    <= 1'b0;
                r_done     <= 1'b1;
                r_zero_hit <= 1'b1;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_SPD_ONE;
            end else begin
                // Phase boundary: every phase lasts exactly r_half clocks.
                r_cnt <= r_half - c_SPD_ONE;
                if (r_state == c_ST_HIGH) begin
                    r_state <= c_ST_LOW;
                    r_drive <= 1'b0;
                end else if ((r_state == c_ST_LOW) && (r_mode == c_MODE_RUN) && (r_remain == '0)) begin
                    r_state <= c_ST_IDLE;
                    r_done  <= 1'b1;
                end else begin
                    // SETUP or LOW: start a new pulse, counting it as issued now.
                    r_state <= c_ST_HIGH;
                    r_drive <= 1'b1;
                    if (r_mode == c_MODE_RUN) begin
                        r_remain <= r_remain - c_STEP_ONE;
                    end
                end
            end
        end
    end

    assign busy        = (r_state != c_ST_IDLE);
    assign done        = r_done;
    assign zero_hit    = r_zero_hit;
    assign remain      = r_remain;
    assign motor_xen   = r_xen;
    assign motor_xrst  = r_xrst;
    assign motor_ms    = r_ms;
    assign motor_drive = r_drive;
    assign motor_dir   = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_fsmotor_step_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsmotor_step_gen
//  Purpose  : Self-checking bench for fsmotor_step_gen. A timeline model
//             computes the expected outputs from the command start cycle with
//             closed-form pulse arithmetic; directed scenarios pin literal values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsmotor_step_gen;

    localparam int MSW = 3;
    localparam int SNW = 16;
    localparam int SDW = 16;
`ifdef FSMOTOR_STEP_GEN_ZPD_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cfg_xen = 1'b0, cfg_xrst = 1'b0;
    logic [MSW-1:0] cfg_ms = '0;
    logic           req_start = 1'b0, req_home = 1'b0, req_stop = 1'b0, req_dir = 1'b0;
    logic [SNW-1:0] req_steps = '0;
    logic [SDW-1:0] req_speed = '0;
    logic           motor_zpd = 1'b0;
    logic           busy, done, zero_hit, motor_xen, motor_xrst, motor_drive, motor_dir;
    logic [SNW-1:0] remain;
    logic [MSW-1:0] motor_ms;

    fsmotor_step_gen #(
        .C_MICROSTEP_WIDTH  (MSW),
        .C_STEP_NUMBER_WIDTH(SNW),
        .C_SPEED_DATA_WIDTH (SDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_xen    (cfg_xen),
        .cfg_xrst   (cfg_xrst),
        .cfg_ms     (cfg_ms),
        .req_start  (req_start),
        .req_home   (req_home),
        .req_stop   (req_stop),
        .req_dir    (req_dir),
        .req_steps  (req_steps),
        .req_speed  (req_speed),
        .busy       (busy),
        .done       (done),
        .zero_hit   (zero_hit),
        .remain     (remain),
        .motor_zpd  (motor_zpd),
        .motor_xen  (motor_xen),
        .motor_xrst (motor_xrst),
        .motor_ms   (motor_ms),
        .motor_drive(motor_drive),
        .motor_dir  (motor_dir)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    logic           e_busy, e_done, e_zh, e_drive, e_dir, e_xen, e_xrst;
    logic [SNW-1:0] e_remain;
    logic [MSW-1:0] e_ms;
    bit             m_active, m_home, m_dir;
    int             m_H, m_S, m_e0, n, k, issued;
    bit             zq0, zq1, zs;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            e_busy = 0; e_done = 0; e_zh = 0; e_drive = 0; e_dir = 0;
            e_xen = 0; e_xrst = 1; e_remain = '0; e_ms = '0;
            m_active = 0; zq0 = 0; zq1 = 0; n = 0;
        end else begin
            n  = n + 1;
            // the sequencer acts on the pin value from two edges earlier
            zs  = zq1;
            zq1 = zq0;
            zq0 = motor_zpd;
            e_done = 0;
            e_xen  = cfg_xen;
            e_xrst = cfg_xrst;
            if (!m_active) begin
                e_ms = cfg_ms;
                if (!req_stop && req_home) begin
                    m_active = 1; m_home = 1; m_dir = 0; m_e0 = n;
                    m_H = (req_speed == 0) ? 1 : int'(req_speed);
                    e_zh = 0; e_remain = '0; e_dir = 0; e_busy = 1; e_drive = 0;
                end else if (!req_stop && req_start) begin
                    e_dir = req_dir; e_zh = 0; e_remain = req_steps;
                    if (req_steps == 0) begin
                        e_done = 1;
                    end else begin
                        m_active = 1; m_home = 0; m_dir = req_dir; m_e0 = n;
                        m_S = int'(req_steps);
                        m_H = (req_speed == 0) ? 1 : int'(req_speed);
                        e_busy = 1; e_drive = 0;
                    end
                end
            end else if (req_stop || (zs && (m_home || (LIMIT && !m_dir)))) begin
                if (!req_stop) e_zh = 1;
                m_active = 0; e_busy = 0; e_done = 1; e_drive = 0;
            end else begin
                k = n - m_e0;
                if (!m_home && k >= m_H + 2 * m_H * m_S) begin
                    m_active = 0; e_busy = 0; e_done = 1; e_drive = 0; e_remain = '0;
                end else begin
                    e_drive = (k >= m_H) && (((k - m_H) % (2 * m_H)) < m_H);
                    if (!m_home) begin
                        issued   = (k < m_H) ? 0 : ((k - m_H) / (2 * m_H) + 1);
                        e_remain = SNW'(m_S - issued);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",   32'(busy),        32'(e_busy));
            chk("done",   32'(done),        32'(e_done));
            chk("zhit",   32'(zero_hit),    32'(e_zh));
            chk("remain", 32'(remain),      32'(e_remain));
            chk("drive",  32'(motor_drive), 32'(e_drive));
            chk("dir",    32'(motor_dir),   32'(e_dir));
            chk("xen",    32'(motor_xen),   32'(e_xen));
            chk("xrst",   32'(motor_xrst),  32'(e_xrst));
            chk("ms",     32'(motor_ms),    32'(e_ms));
        end
    end

    // ---------------- helpers ----------------
    task automatic start_cmd(input int steps, input int speed, input bit dir);
        req_steps = SNW'(steps); req_speed = SDW'(speed); req_dir = dir; req_start = 1;
        @(negedge clk);
        req_start = 0;
    endtask

    task automatic home_cmd(input int speed);
        req_speed = SDW'(speed); req_home = 1;
        @(negedge clk);
        req_home = 0;
    endtask

    task automatic count_edges(input int num, input bit rising, input int bound, output int cycles);
        int   cnt;
        logic pd;
        cnt = 0; cycles = 0; pd = motor_drive;
        while (cnt < num && cycles < bound) begin
            @(negedge clk);
            cycles++;
            if (rising ? (motor_drive && !pd) : (!motor_drive && pd)) cnt++;
            pd = motor_drive;
        end
        chk("edge_wait", cnt, num);
    endtask

    task automatic wait_idle(input int bound, output int cycles, output int rises);
        logic pd;
        cycles = 0; rises = 0; pd = motor_drive;
        while (busy && cycles < bound) begin
            @(negedge clk);
            cycles++;
            if (motor_drive && !pd) rises++;
            pd = motor_drive;
        end
        chk("idle_wait", 32'(busy), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c, r;
        rst = 1;
        @(posedge clk);
        cmp_en = 1;
        @(negedge clk);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_xrst",  32'(motor_xrst), 1);
        chk("rst_drive", 32'(motor_drive), 0);
        chk("rst_remain", 32'(remain), 0);
        rst = 0;
        @(negedge clk);

        // run of 4 steps, H = 3
        cfg_xen = 1; cfg_ms = 3'b010;
        @(negedge clk);
        start_cmd(4, 3, 1);
        chk("t1_dir", 32'(motor_dir), 1);
        count_edges(1, 1'b1, 50, c);
        chk("t1_first_rise", c, 3);
        count_edges(1, 1'b1, 50, c);
        chk("t1_period", c, 6);
        wait_idle(100, c, r);
        chk("t1_tail_cycles", c, 18);
        chk("t1_tail_rises", r, 2);
        chk("t1_done", 32'(done), 1);
        chk("t1_remain", 32'(remain), 0);
        chk("t1_ms", 32'(motor_ms), 2);
        @(negedge clk);

        // zero-step start
        start_cmd(0, 3, 0);
        chk("t2_done", 32'(done), 1);
        chk("t2_busy", 32'(busy), 0);
        @(negedge clk);
        chk("t2_done_clr", 32'(done), 0);

        // homing, zpd after 5 pulses
        home_cmd(2);
        count_edges(5, 1'b0, 200, c);
        motor_zpd = 1;
        wait_idle(10, c, r);
        chk("t3_latency_ok", 32'(c <= 4), 1);
        chk("t3_done", 32'(done), 1);
        chk("t3_zhit", 32'(zero_hit), 1);
        chk("t3_dir", 32'(motor_dir), 0);
        motor_zpd = 0;
        repeat (3) @(negedge clk);

        // long run aborted during 10th HIGH phase
        cfg_ms = 3'd1;
        @(negedge clk);
        start_cmd(100, 5, 1);
        cfg_ms = 3'd5;
        count_edges(10, 1'b1, 2000, c);
        req_stop = 1;
        @(negedge clk);
        req_stop = 0;
        chk("t4_drive", 32'(motor_drive), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_done", 32'(done), 1);
        chk("t4_remain", 32'(remain), 90);
        chk("t4_ms_frozen", 32'(motor_ms), 1);
        @(negedge clk);
        chk("t4_ms_idle", 32'(motor_ms), 5);

        // start and stop together, then reset mid-pulse
        req_start = 1; req_stop = 1; req_steps = 16'd5; req_speed = 16'd2;
        @(negedge clk);
        req_start = 0; req_stop = 0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        start_cmd(3, 2, 1);
        count_edges(1, 1'b1, 50, c);
        #2 rst = 1;
        #1;
        chk("t5_rst_drive", 32'(motor_drive), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // run toward zero with zpd after 7 pulses
        start_cmd(50, 5, 0);
        count_edges(7, 1'b0, 1000, c);
        motor_zpd = 1;
        wait_idle(1000, c, r);
`ifdef FSMOTOR_STEP_GEN_ZPD_LIMIT_EN
        chk("t6_rises", r, 0);
        chk("t6_remain", 32'(remain), 43);
        chk("t6_zhit", 32'(zero_hit), 1);
`else
        chk("t6_rises", r, 43);
        chk("t6_remain", 32'(remain), 0);
        chk("t6_zhit", 32'(zero_hit), 0);
`endif
        motor_zpd = 0;
        repeat (3) @(negedge clk);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            req_start = ($urandom_range(0, 7) == 0);
            req_home  = ($urandom_range(0, 19) == 0);
            req_stop  = ($urandom_range(0, 39) == 0);
            req_steps = SNW'($urandom_range(0, 6));
            req_speed = SDW'($urandom_range(0, 4));
            req_dir   = 1'($urandom_range(0, 1));
            cfg_xen   = 1'($urandom_range(0, 1));
            cfg_xrst  = 1'($urandom_range(0, 1));
            cfg_ms    = MSW'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) motor_zpd = ~motor_zpd;
            @(negedge clk);
        end
        req_start = 0; req_home = 0; req_stop = 0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
